// File: rtl/l1_snoop_agent_if.sv
// Snoop-agent bus bundle: snoop request channel, cache array lookup/update
// port and response channel. The agent connects through the slave modport;
// the bus/core/array side uses the master modport.
interface l1_snoop_agent_if #(
    parameter int LA        = 6,
    parameter int TAG       = 4,
    parameter int LINE_BITS = 8
);
    // snoop request channel
    logic                 snp_valid;
    logic                 snp_ready;
    logic [LA-1:0]        snp_addr;
    logic [1:0]           snp_req;
    // cache array access
    logic                 cpu_busy;
    logic [LA-1:0]        cache_addr;
    logic [2:0]           lk_state;
    logic [TAG-1:0]       lk_tag;
    logic [LINE_BITS-1:0] lk_data;
    logic                 upd_valid;
    logic [2:0]           upd_state;
    // response channel
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_hit;
    logic                 resp_supply;
    logic [LINE_BITS-1:0] resp_data;

    modport slave (
        input  snp_valid, snp_addr, snp_req, cpu_busy,
        input  lk_state, lk_tag, lk_data, resp_ready,
        output snp_ready, cache_addr, upd_valid, upd_state,
        output resp_valid, resp_hit, resp_supply, resp_data
    );

    modport master (
        output snp_valid, snp_addr, snp_req, cpu_busy,
        output lk_state, lk_tag, lk_data, resp_ready,
        input  snp_ready, cache_addr, upd_valid, upd_state,
        input  resp_valid, resp_hit, resp_supply, resp_data
    );
endinterface

// File: rtl/l1_snoop_agent.sv
// L1 snoop agent for a private MOESI L1. Snoops are queued in a small FIFO,
// looked up in the array whenever the core leaves it free, and answered with
// one response per request on a valid/ready channel.
// Optional macro SNOOP_STATS_EN adds saturating hit / invalidate counters.
module l1_snoop_agent #(
    parameter int ADDR_BITS   = 8,
    parameter int OFFSET_BITS = 2,
    parameter int INDEX_BITS  = 2,
    parameter int LINE_BITS   = 8,
    parameter int QDEPTH      = 2,
    parameter int STAT_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef SNOOP_STATS_EN
    output logic [STAT_BITS-1:0] stat_hits,
    output logic [STAT_BITS-1:0] stat_invals,
`endif
    l1_snoop_agent_if.slave      bus
);
    localparam int LA  = ADDR_BITS - OFFSET_BITS;
    localparam int PW  = $clog2(QDEPTH);

    localparam logic [2:0] ST_I = 3'd0;
    localparam logic [2:0] ST_S = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_O = 3'd3;
    localparam logic [2:0] ST_M = 3'd4;

    localparam logic [1:0] BUS_RD   = 2'd0;
    localparam logic [1:0] BUS_RDX  = 2'd1;
    localparam logic [1:0] BUS_UPGR = 2'd2;
    localparam logic [1:0] BUS_WB   = 2'd3;

    if (QDEPTH < 2 || (1 << PW) != QDEPTH || STAT_BITS < 1) begin : g_bad_param
        $error("l1_snoop_agent: QDEPTH must be a power of two >= 2, STAT_BITS >= 1");
    end

    typedef enum logic {IDLE, RESP} state_e;

    state_e               state_q, state_d;
    logic [LA-1:0]        addr_mem_q [QDEPTH];
    logic [1:0]           req_mem_q  [QDEPTH];
    logic [PW-1:0]        wr_q, rd_q;
    logic [PW:0]          cnt_q;
    logic                 resp_hit_q, resp_supply_q;
    logic [LINE_BITS-1:0] resp_data_q;

    logic                 empty, full, push, lookup;
    logic [LA-1:0]        head_addr;
    logic [1:0]           head_req;
    logic                 hit, supply;
    logic [2:0]           nxt_st;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (PW+1)'(QDEPTH));
    assign push      = bus.snp_valid && !full;
    assign head_addr = addr_mem_q[rd_q];
    assign head_req  = req_mem_q[rd_q];

    // Request FIFO; a pop happens exactly on a lookup cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                addr_mem_q[i] <= '0;
                req_mem_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                addr_mem_q[wr_q] <= bus.snp_addr;
                req_mem_q[wr_q]  <= bus.snp_req;
                wr_q             <= wr_q + 1'b1;
            end
            if (lookup) rd_q <= rd_q + 1'b1;
            if (push && !lookup)      cnt_q <= cnt_q + 1'b1;
            else if (!push && lookup) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Hit detection and MOESI transition for the head request.
    always_comb begin
        hit    = (bus.lk_state != ST_I) &&
                 (bus.lk_tag == head_addr[LA-1:INDEX_BITS]);
        supply = 1'b0;
        nxt_st = bus.lk_state;
        case (head_req)
            BUS_RD: begin
                supply = hit && (bus.lk_state inside {ST_E, ST_O, ST_M});
                if (bus.lk_state == ST_E) nxt_st = ST_S;
                if (bus.lk_state == ST_M) nxt_st = ST_O;
            end
            BUS_RDX: begin
                supply = hit && (bus.lk_state inside {ST_E, ST_O, ST_M});
                nxt_st = ST_I;
            end
            BUS_UPGR: nxt_st = ST_I;
            BUS_WB:   nxt_st = bus.lk_state;
            default:  nxt_st = bus.lk_state;
        endcase
    end

    // FSM next state: one lookup in IDLE, then hold the response until taken.
    always_comb begin
        state_d = state_q;
        lookup  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !bus.cpu_busy) begin
                    lookup  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Response registers, captured on the lookup cycle and held through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_hit_q    <= 1'b0;
            resp_supply_q <= 1'b0;
            resp_data_q   <= '0;
        end else if (lookup) begin
            resp_hit_q    <= hit;
            resp_supply_q <= supply;
            resp_data_q   <= supply ? bus.lk_data : '0;
        end
    end

    assign bus.snp_ready   = !full;
    assign bus.cache_addr  = empty ? '0 : head_addr;
    assign bus.upd_valid   = lookup && hit && (nxt_st != bus.lk_state);
    assign bus.upd_state   = bus.upd_valid ? nxt_st : ST_I;
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_hit    = resp_hit_q;
    assign bus.resp_supply = resp_supply_q;
    assign bus.resp_data   = resp_data_q;

`ifdef SNOOP_STATS_EN
    logic [STAT_BITS-1:0] hits_q, invals_q;

    // Saturating statistics counters, sampled on lookup cycles only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hits_q   <= '0;
            invals_q <= '0;
        end else begin
            if (lookup && hit && hits_q != '1) hits_q <= hits_q + 1'b1;
            if (bus.upd_valid && bus.upd_state == ST_I && invals_q != '1)
                invals_q <= invals_q + 1'b1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_invals = invals_q;
`endif
endmodule

// File: tb/tb_l1_snoop_agent.sv
// Directed bench for l1_snoop_agent: a small combinational array model feeds
// lk_* from cache_addr; expected values are hand-computed per vector.
module tb_l1_snoop_agent;
    localparam int LA = 6, TAG = 4, LB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [2:0]    m_st [4];
    logic [TAG-1:0] m_tg [4];
    logic [LB-1:0] m_dt [4];

    l1_snoop_agent_if #(.LA(LA), .TAG(TAG), .LINE_BITS(LB)) bus_if ();

`ifdef SNOOP_STATS_EN
    logic [15:0] stat_hits, stat_invals;
`endif

    l1_snoop_agent #(
        .ADDR_BITS(8), .OFFSET_BITS(2), .INDEX_BITS(2),
        .LINE_BITS(LB), .QDEPTH(2), .STAT_BITS(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef SNOOP_STATS_EN
        .stat_hits  (stat_hits),
        .stat_invals(stat_invals),
`endif
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // Array model: index is the low line-address bits.
    always_comb begin
        bus_if.lk_state = m_st[bus_if.cache_addr[1:0]];
        bus_if.lk_tag   = m_tg[bus_if.cache_addr[1:0]];
        bus_if.lk_data  = m_dt[bus_if.cache_addr[1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int idx, input logic [2:0] st,
                            input logic [3:0] tg, input logic [7:0] dt);
        m_st[idx] = st;
        m_tg[idx] = tg;
        m_dt[idx] = dt;
    endtask

    // Single request with resp_ready=1: push, lookup at t+1, response at t+2.
    task automatic do_req(input string tag, input logic [5:0] addr, input logic [1:0] req,
                          input logic uv, input logic [2:0] us,
                          input logic h, input logic s, input logic [7:0] d);
        bus_if.snp_valid = 1'b1;
        bus_if.snp_addr  = addr;
        bus_if.snp_req   = req;
        #1 chk({tag, " ready"}, 32'(bus_if.snp_ready), 32'd1);
        tick();
        bus_if.snp_valid = 1'b0;
        #1;
        chk({tag, " cache_addr"}, 32'(bus_if.cache_addr), 32'(addr));
        chk({tag, " upd_valid"}, 32'(bus_if.upd_valid), 32'(uv));
        if (uv) chk({tag, " upd_state"}, 32'(bus_if.upd_state), 32'(us));
        chk({tag, " early_valid"}, 32'(bus_if.resp_valid), 32'd0);
        tick();
        chk({tag, " resp_valid"}, 32'(bus_if.resp_valid), 32'd1);
        chk({tag, " resp_hit"}, 32'(bus_if.resp_hit), 32'(h));
        chk({tag, " resp_supply"}, 32'(bus_if.resp_supply), 32'(s));
        chk({tag, " resp_data"}, 32'(bus_if.resp_data), 32'(d));
        tick();
        chk({tag, " resp_done"}, 32'(bus_if.resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_line(i, 3'd0, 4'd0, 8'd0);
        bus_if.snp_valid  = 1'b0;
        bus_if.snp_addr   = '0;
        bus_if.snp_req    = '0;
        bus_if.cpu_busy   = 1'b0;
        bus_if.resp_ready = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("rst snp_ready", 32'(bus_if.snp_ready), 32'd1);
        chk("rst resp_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("rst upd_valid", 32'(bus_if.upd_valid), 32'd0);
        chk("rst cache_addr", 32'(bus_if.cache_addr), 32'd0);
        chk("rst resp_data", 32'(bus_if.resp_data), 32'd0);

        // M line read-snooped: M->O, supply A5
        set_line(1, 3'd4, 4'h1, 8'hA5);
        do_req("rd_m", 6'h05, 2'd0, 1'b1, 3'd3, 1'b1, 1'b1, 8'hA5);
        // S line RDX: ->I, no supply
        set_line(1, 3'd1, 4'h1, 8'hA5);
        do_req("rdx_s", 6'h05, 2'd1, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00);
        // UPGR on I line: miss
        set_line(1, 3'd0, 4'h1, 8'hA5);
        do_req("upgr_i", 6'h05, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
        // tag mismatch on E line
        set_line(1, 3'd2, 4'h3, 8'hA5);
        do_req("tag_miss", 6'h05, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
        // WB on O line: hit, no change, no supply
        set_line(1, 3'd3, 4'h1, 8'hA5);
        do_req("wb_o", 6'h05, 2'd3, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00);
        // E line RD: E->S, supply
        set_line(2, 3'd2, 4'h2, 8'h3C);
        do_req("rd_e", 6'h0A, 2'd0, 1'b1, 3'd1, 1'b1, 1'b1, 8'h3C);

        // core busy: fill FIFO, third push refused, in-order drain
        set_line(1, 3'd4, 4'h1, 8'hA5);
        bus_if.cpu_busy  = 1'b1;
        bus_if.snp_valid = 1'b1;
        bus_if.snp_req   = 2'd0;
        bus_if.snp_addr  = 6'h05;
        tick();
        bus_if.snp_addr  = 6'h0A;
        tick();
        bus_if.snp_addr  = 6'h11;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("busy ready", 32'(bus_if.snp_ready), 32'd0);
            chk("busy upd", 32'(bus_if.upd_valid), 32'd0);
            chk("busy head", 32'(bus_if.cache_addr), 32'h05);
            tick();
            bus_if.snp_valid = 1'b0;
        end
        bus_if.cpu_busy = 1'b0;
        #1;
        chk("drain1 upd_state", 32'(bus_if.upd_state), 32'd3);
        chk("drain1 upd_valid", 32'(bus_if.upd_valid), 32'd1);
        tick();
        chk("drain1 data", 32'(bus_if.resp_data), 32'hA5);
        chk("drain1 ready", 32'(bus_if.snp_ready), 32'd1);
        tick();
        chk("drain2 addr", 32'(bus_if.cache_addr), 32'h0A);
        chk("drain2 upd_state", 32'(bus_if.upd_state), 32'd1);
        tick();
        chk("drain2 data", 32'(bus_if.resp_data), 32'h3C);
        tick();
        chk("drain empty", 32'(bus_if.cache_addr), 32'd0);
        chk("drain idle", 32'(bus_if.resp_valid), 32'd0);

        // response backpressure: hold stable, no lookup until handshake
        bus_if.snp_valid = 1'b1;
        bus_if.snp_addr  = 6'h05;
        tick();
        bus_if.snp_valid  = 1'b0;
        bus_if.resp_ready = 1'b0;
        tick();
        bus_if.snp_valid = 1'b1;
        bus_if.snp_addr  = 6'h0A;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp valid", 32'(bus_if.resp_valid), 32'd1);
            chk("bp data", 32'(bus_if.resp_data), 32'hA5);
            chk("bp hit", 32'(bus_if.resp_hit), 32'd1);
            chk("bp no_lookup", 32'(bus_if.upd_valid), 32'd0);
            tick();
            bus_if.snp_valid = 1'b0;
        end
        bus_if.resp_ready = 1'b1;
        tick();
        chk("bp next addr", 32'(bus_if.cache_addr), 32'h0A);
        chk("bp next upd", 32'(bus_if.upd_valid), 32'd1);
        tick();
        chk("bp next data", 32'(bus_if.resp_data), 32'h3C);
        tick();

        // reset while a response is pending
        bus_if.snp_valid = 1'b1;
        bus_if.snp_addr  = 6'h05;
        tick();
        bus_if.snp_valid  = 1'b0;
        bus_if.resp_ready = 1'b0;
        tick();
        chk("pre_rst valid", 32'(bus_if.resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst valid", 32'(bus_if.resp_valid), 32'd0);
        chk("mid_rst data", 32'(bus_if.resp_data), 32'd0);
        chk("mid_rst hit", 32'(bus_if.resp_hit), 32'd0);
        chk("mid_rst upd", 32'(bus_if.upd_valid), 32'd0);
        chk("mid_rst addr", 32'(bus_if.cache_addr), 32'd0);
        tick();
        reset_n = 1'b1;
        bus_if.resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst valid", 32'(bus_if.resp_valid), 32'd0);
            chk("post_rst empty", 32'(bus_if.cache_addr), 32'd0);
        end
        chk("post_rst ready", 32'(bus_if.snp_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1_snoop_agent.md
Name: l1_snoop_agent

Overview:
- Parametrised next-generation L1 bus-snoop agent for one core's private MOESI L1 cache.
- Buffers incoming bus snoop requests in a small FIFO and arbitrates cache-array access against the core, which has priority.
- Performs one lookup and state update per request and returns a per-request response on a valid/ready channel.
- Sits between the shared snoop bus and the L1 tag/data array; one instance per core.

Parameters:
- ADDR_BITS, 8, byte address width.
- OFFSET_BITS, 2, line offset bits; line address width LA = ADDR_BITS-OFFSET_BITS.
- INDEX_BITS, 2, L1 index bits; tag width TAG = LA-INDEX_BITS.
- LINE_BITS, 8, cacheline data width.
- QDEPTH, 2, snoop FIFO depth, power of two, >=2.
- STAT_BITS, 16, statistics counter width (only with SNOOP_STATS_EN).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- snp_valid  in  1  snoop request valid
- snp_ready  out  1  FIFO can accept a request
- snp_addr  in  LA  line address
- snp_req  in  2  0=BUS_RD, 1=BUS_RDX, 2=BUS_UPGR, 3=BUS_WB
- cpu_busy  in  1  core is using the cache array this cycle
- cache_addr  out  LA  lookup line address
- lk_state  in  3  looked-up MOESI state: I=0, S=1, E=2, O=3, M=4
- lk_tag  in  TAG  looked-up tag
- lk_data  in  LINE_BITS  looked-up line data
- upd_valid  out  1  write upd_state to the line at cache_addr
- upd_state  out  3  new MOESI state
- resp_valid  out  1  response valid
- resp_ready  in  1  bus accepts response
- resp_hit  out  1  line present (state != I, tag match)
- resp_supply  out  1  this cache supplies data
- resp_data  out  LINE_BITS  supplied data; 0 when resp_supply=0

Behaviour:
- Clocking and reset: single clock clk; reset_n is asynchronous, active-low. Reset empties the FIFO and returns the FSM to IDLE.
- Reset values: snp_ready=1 after reset deassertion; every other output 0. Reset mid-operation drops queued and pending responses without a handshake.
- FIFO: pushes when snp_valid && snp_ready; snp_ready = !full. No push-when-full bypass, even if a pop occurs the same cycle. Pointers wrap modulo QDEPTH. Requests are serviced strictly in order.
- FSM, 2 states: IDLE and RESP.
- IDLE, FIFO non-empty and cpu_busy=0 (lookup cycle):
  - cache_addr = head address; the array returns lk_* combinationally in the same cycle.
  - Compute the response, drive upd_valid/upd_state combinationally, pop the head, register the response, go to RESP.
- IDLE, cpu_busy=1 or FIFO empty: stall. cache_addr = head address (0 if empty); upd_valid=0.
- RESP: hold resp_* stable while resp_valid=1. On resp_ready, go to IDLE. No lookup occurs in RESP.
- Latency: a request accepted in cycle t gets earliest lookup in t+1 and resp_valid in t+2. Throughput is one request per 2 cycles when resp_ready=1.
- Hit: lk_state != I and lk_tag == cache_addr[LA-1:INDEX_BITS].
- Miss: hit=0, supply=0, upd_valid=0.
- Hit actions (upd_valid=1 only when the state changes):
  - BUS_RD: E->S, M->O; S and O unchanged. Supply when state is E, O or M.
  - BUS_RDX: any state -> I. Supply when state is E, O or M.
  - BUS_UPGR: any state -> I. No supply.
  - BUS_WB: no change, no supply; resp_hit still reported.
- A response is produced for every request, misses included.
- Simultaneous push and pop in the same cycle is allowed when the FIFO is not full.

Optional Feature:
- Macro: SNOOP_STATS_EN.
- With it defined, add outputs:
  - stat_hits [STAT_BITS]: counts lookup cycles with hit=1.
  - stat_invals [STAT_BITS]: counts lookup cycles writing upd_state=I.
  - Both counters saturate at all-ones and reset to 0.
- Without it: no counters and no extra ports; remaining behaviour identical.

Test Plan:
- Line 0x05 in M, data 0xA5; BUS_RD addr 0x05 -> upd M->O in lookup cycle; resp hit=1, supply=1, data=0xA5 at t+2.
- Line in S; BUS_RDX -> upd_state=I; resp hit=1, supply=0, data=0. Then BUS_UPGR on an I line -> hit=0, upd_valid=0.
- Tag mismatch (lk_tag=0x3, addr tag 0x1, state E) with BUS_RD -> hit=0, upd_valid=0, response still issued.
- cpu_busy=1 for 3 cycles with 2 queued requests (QDEPTH=2) -> snp_ready=0, no lookup; responses come in order after release. A third push while full is refused.
- resp_ready held 0 for 4 cycles -> resp_* stable; next lookup starts only after the handshake.
- reset_n pulsed low while in RESP -> all outputs 0 immediately; FIFO empty; no response delivered after release.
